// File: rtl/segment_capture.sv
// rtl/segment_capture.sv - 7-segment bus observer: debounce, decode, strobe per new digit
//
// Purpose: samples a 7-segment bus, waits for a pattern to be stable for
// STABLE_CYCLES clocks, decodes it to a hex digit and reports each new digit
// with a one-cycle strobe. Non-hex, non-blank patterns raise an error strobe
// and a sticky error flag.
//
// Parameters:
//   STABLE_CYCLES  identical samples required before commit (1..255)
//   CNT_W          width of digit_count
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   segments     in   [6:0] segment bus, bit0 = a .. bit6 = g, active high
//   digit        out  [3:0] last committed hex digit
//   digit_valid  out  one-cycle strobe on a newly committed digit
//   invalid      out  one-cycle strobe on a committed invalid pattern
//   err_sticky   out  set by invalid, cleared only by rst
//   digit_count  out  [CNT_W-1:0] digit_valid strobes since reset (wraps)
//   history      out  [15:0] last four digits, newest in [3:0]
//
// Optional feature: define SEGCAP_HISTORY_EN to build the history shift
// register; otherwise history is tied to zero.

module segment_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       segments,
   output logic [3:0]       digit,
   output logic             digit_valid,
   output logic             invalid,
   output logic             err_sticky,
   output logic [CNT_W-1:0] digit_count,
   output logic [15:0]      history
);

   typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

   localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

   state_t     state, state_d;
   logic [6:0] seg_q;
   logic [6:0] cand, cand_d;
   logic [7:0] stab, stab_d;
   logic [6:0] committed;

   logic       load;
   logic       commit;
   logic [6:0] commit_pat;
   logic       differs;
   logic       valid_d;
   logic       invalid_d;
   logic [5:0] dec;

   // {is_hex, is_blank, value}
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      case (p)
         7'h3F:   r = {2'b10, 4'h0};
         7'h06:   r = {2'b10, 4'h1};
         7'h5B:   r = {2'b10, 4'h2};
         7'h4F:   r = {2'b10, 4'h3};
         7'h66:   r = {2'b10, 4'h4};
         7'h6D:   r = {2'b10, 4'h5};
         7'h7D:   r = {2'b10, 4'h6};
         7'h07:   r = {2'b10, 4'h7};
         7'h7F:   r = {2'b10, 4'h8};
         7'h6F:   r = {2'b10, 4'h9};
         7'h77:   r = {2'b10, 4'hA};
         7'h7C:   r = {2'b10, 4'hB};
         7'h39:   r = {2'b10, 4'hC};
         7'h5E:   r = {2'b10, 4'hD};
         7'h79:   r = {2'b10, 4'hE};
         7'h71:   r = {2'b10, 4'hF};
         7'h00:   r = {2'b01, 4'h0};
         default: r = {2'b00, 4'h0};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state;
      cand_d     = cand;
      stab_d     = stab;
      load       = 1'b0;
      commit     = 1'b0;
      commit_pat = cand;

      case (state)
         IDLE: load = 1'b1;
         TRACK: begin
            if (seg_q != cand) begin
               load = 1'b1;
            end else if (stab < STAB_MAX) begin
               stab_d = stab + 8'd1;
               if (stab + 8'd1 == STAB_MAX) begin
                  commit  = 1'b1;
                  state_d = LOCKED;
               end
            end else begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (seg_q != cand) load = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A fresh candidate counts as its first stable sample; with a
      // one-sample threshold it commits immediately.
      if (load) begin
         cand_d     = seg_q;
         stab_d     = 8'd1;
         commit_pat = seg_q;
         if (STAB_MAX == 8'd1) begin
            commit  = 1'b1;
            state_d = LOCKED;
         end else begin
            state_d = TRACK;
         end
      end
   end

   // Re-commits of the same pattern (e.g. after a short glitch) are silent.
   assign dec       = decode(commit_pat);
   assign differs   = commit && (commit_pat != committed);
   assign valid_d   = differs && dec[5];
   assign invalid_d = differs && !dec[5] && !dec[4];

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         seg_q       <= 7'h00;
         cand        <= 7'h00;
         stab        <= 8'd0;
         committed   <= 7'h00;
         digit       <= 4'h0;
         digit_valid <= 1'b0;
         invalid     <= 1'b0;
         err_sticky  <= 1'b0;
         digit_count <= '0;
      end else begin
         state       <= state_d;
         seg_q       <= segments;
         cand        <= cand_d;
         stab        <= stab_d;
         digit_valid <= valid_d;
         invalid     <= invalid_d;
         if (differs) committed <= commit_pat;
         if (valid_d) begin
            digit       <= dec[3:0];
            digit_count <= digit_count + 1'b1;
         end
         if (invalid_d) err_sticky <= 1'b1;
      end
   end

`ifdef SEGCAP_HISTORY_EN
   logic [15:0] hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 16'h0000;
      end else if (valid_d) begin
         hist_q <= {hist_q[11:0], dec[3:0]};
      end
   end

   assign history = hist_q;
`else
   assign history = 16'h0000;
`endif

endmodule
